// File: rtl/core_id_regfile_mp_if.sv
// Bundle of read, write, scoreboard and status signals for core_id_regfile_mp.
// master = requester side (decode / writeback), slave = register file.
interface core_id_regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 2
);
   logic [NRD*ADDR_W-1:0] raddr;
   logic [NRD*DATA_W-1:0] rd_data;
   logic [NRD-1:0]        rd_pend;
   logic                  we_a;
   logic [ADDR_W-1:0]     waddr_a;
   logic [DATA_W-1:0]     wdata_a;
   logic                  we_b;
   logic [ADDR_W-1:0]     waddr_b;
   logic [DATA_W-1:0]     wdata_b;
   logic                  sb_set;
   logic [ADDR_W-1:0]     sb_addr;
   logic                  init_busy;

   modport master (
      output raddr, we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b, sb_set, sb_addr,
      input  rd_data, rd_pend, init_busy
   );

   modport slave (
      input  raddr, we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b, sb_set, sb_addr,
      output rd_data, rd_pend, init_busy
   );
endinterface

// File: rtl/core_id_regfile_mp.sv
// Multi-port decode-stage register file with a pending-write scoreboard.
// Two write ports (B wins on same-address collision), NRD combinational
// read ports, register 0 hardwired to zero, and a post-reset sequence that
// clears one register per cycle before normal operation starts.
// Optional macro RF_BYPASS_EN: forward same-cycle write data to read ports.
module core_id_regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 2
) (
   input logic clk,
   input logic rst,
   core_id_regfile_mp_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {INIT, RUN} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  pend_q;
   logic [DEPTH-1:0]  pend_d;

   logic wrA;
   logic wrB;
   logic sbValid;

   // Port B always wins a collision, so A is suppressed when both target the same register
   assign wrB     = (state_q == RUN) && bus.we_b && (bus.waddr_b != '0);
   assign wrA     = (state_q == RUN) && bus.we_a && (bus.waddr_a != '0) &&
                    !(bus.we_b && (bus.waddr_b == bus.waddr_a));
   assign sbValid = (state_q == RUN) && bus.sb_set && (bus.sb_addr != '0);

   assign bus.init_busy = (state_q == INIT);

   // Scoreboard next state: writes retire a pending destination, allocation sets it afterwards so it wins
   always_comb begin
      pend_d = pend_q;
      if (state_q == INIT) begin
         pend_d = '0;
      end else begin
         if (wrA) pend_d[bus.waddr_a] = 1'b0;
         if (wrB) pend_d[bus.waddr_b] = 1'b0;
         if (sbValid) pend_d[bus.sb_addr] = 1'b1;
      end
   end

   // Controller: INIT sweeps the clear counter over every register, RUN commits writes and scoreboard
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
         pend_q  <= '0;
      end else begin
         pend_q <= pend_d;
         case (state_q)
            INIT: begin
               regs_q[cnt_q] <= '0;
               cnt_q         <= cnt_q + 1'b1;
               if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (wrA) regs_q[bus.waddr_a] <= bus.wdata_a;
               if (wrB) regs_q[bus.waddr_b] <= bus.wdata_b;
            end
            default: state_q <= INIT;
         endcase
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : gRd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rdData;
      logic              rdPend;
`ifdef RF_BYPASS_EN
      logic              sbHit;
      assign sbHit = bus.sb_set && (bus.sb_addr == ra);
`endif

      assign ra = bus.raddr[k*ADDR_W +: ADDR_W];

      // Read port k: zero while clearing or for register 0, otherwise stored contents (plus optional forwarding)
      always_comb begin
         rdData = '0;
         rdPend = 1'b0;
         if ((state_q == RUN) && (ra != '0)) begin
            rdData = regs_q[ra];
            rdPend = pend_q[ra];
`ifdef RF_BYPASS_EN
            if (wrB && (bus.waddr_b == ra)) begin
               rdData = bus.wdata_b;
               rdPend = sbHit;
            end else if (wrA && (bus.waddr_a == ra)) begin
               rdData = bus.wdata_a;
               rdPend = sbHit;
            end
`endif
         end
      end

      assign bus.rd_data[k*DATA_W +: DATA_W] = rdData;
      assign bus.rd_pend[k]                  = rdPend;
   end
endmodule

// File: doc/core_id_regfile_mp.md
CORE_ID_REGFILE_MP -- requirements
Module: core_id_regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32: register data width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; DEPTH = 2^ADDR_W registers.
REQ-003 Parameter NRD, default 2: number of read ports, packed port 0 in the LSBs.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 raddr  in  NRD*ADDR_W  read addresses.
REQ-007 rd_data  out  NRD*DATA_W  read data, combinational from raddr and state.
REQ-008 rd_pend  out  NRD  pending-write (scoreboard) bit of each addressed register.
REQ-009 we_a, waddr_a, wdata_a  in  1/ADDR_W/DATA_W  write port A.
REQ-010 we_b, waddr_b, wdata_b  in  1/ADDR_W/DATA_W  write port B.
REQ-011 sb_set, sb_addr  in  1/ADDR_W  mark a register pending (destination allocated).
REQ-012 init_busy  out  1  high while the post-reset clear sequence runs.

Function
REQ-013 FSM states INIT and RUN; INIT clears one register per cycle, address counter 0..DEPTH-1; after clearing DEPTH-1 the next state is RUN.
REQ-014 init_busy = 1 exactly while in INIT, i.e. DEPTH cycles after reset release.
REQ-015 In INIT: write ports and sb_set ignored; rd_data = 0; rd_pend = 0.
REQ-016 In RUN: we_x=1 writes wdata_x to waddr_x at the rising edge.
REQ-017 Both ports writing the same address in one cycle: port B data stored; port A discarded.
REQ-018 Register 0 always reads 0; writes to address 0 are discarded; pending bit 0 never sets.
REQ-019 A write clears the pending bit of its address; sb_set sets the pending bit of sb_addr.
REQ-020 sb_set and a write to the same address in the same cycle: pending ends at 1 (set wins).
REQ-021 Each read port is independent; any number of ports may read the same address.
REQ-022 rd_pend[k] reflects the registered pending bit of raddr port k (no forwarding of same-cycle set or clear).

Reset
REQ-023 rst=0 at a rising edge: state to INIT, counter to 0, all pending bits to 0; init_busy=1 from that edge onward.
REQ-024 Reset asserted mid-INIT or in RUN restarts the full clear sequence from address 0.
REQ-025 Output values while in reset/INIT: rd_data=0, rd_pend=0, init_busy=1.

Configuration
REQ-026 Macro RF_BYPASS_EN defined: in RUN, a read port whose raddr (nonzero) matches an active write address returns that cycle's write data (port B over A on collision) and rd_pend of that port reads 0 unless sb_set targets the same address.
REQ-027 RF_BYPASS_EN undefined: reads return only stored contents; new data visible the cycle after the write edge.

Verification
REQ-028 Release reset, DATA_W=32, ADDR_W=5 -> init_busy high 32 cycles then low; all 32 registers read 0.
REQ-029 Write reg i = i+1 for i=0..31 via port A, then read all on both ports -> reg0=0, reg i=i+1 otherwise.
REQ-030 Same cycle we_a/we_b to reg 7 with 0xAAAA0000/0x0000BBBB -> reg 7 reads 0x0000BBBB.
REQ-031 sb_set reg 5, next cycle read -> rd_pend=1; write reg 5 -> pending 0 next cycle; sb_set+write reg 5 together -> pending 1.
REQ-032 With RF_BYPASS_EN, raddr=9 while writing 0x12345678 to reg 9 -> rd_data=0x12345678 same cycle; without it, old value, new value next cycle.
REQ-033 Assert rst for one cycle at counter=10 during INIT -> init_busy stays high, full 32-cycle clear restarts, writes during INIT lost.
